// File: rtl/as512_pkg.sv
// rtl/as512_pkg.sv - shared types and constants for the as512 bus bridge
package as512_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam logic [15:0] READ_ABORT_VAL = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/as512_bus_timeout.sv
// rtl/as512_bus_timeout.sv - loadable wait counter with terminal-count flag
module as512_bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  // tc marks the REQ cycle in which the count reaches TIMEOUT with this increment
  localparam logic [15:0] TC_VAL = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  // Counter cleared when a transfer is accepted, advanced while it waits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 16'd1;
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/as512_bus_bridge.sv
// rtl/as512_bus_bridge.sv - demux of the as512 multiplexed bus onto a req/ready memory port
module as512_bus_bridge
  import as512_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int AUTOINC = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       bus_dout,
  output logic [15:0]       bus_din,
  input  logic              len1,
  input  logic              len2,
  input  logic              rw,
  input  logic              opreq,
  output logic              wait_o,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  bridge_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_fresh_q;
  logic [ADDR_W-1:0] op_addr;
  logic              accept, done_ok, done_tmo, viol, both_len, tmo_tc;

  // A strobe with no address phase since the previous one walks to the next word
  assign op_addr  = (AUTOINC != 0 && !addr_fresh_q) ? addr_q + ADDR_ONE : addr_q;
  assign both_len = len1 & len2;
  // The core is stalled in the strobe cycle and for as long as the request is open
  assign wait_o   = opreq | (state_q == REQ);

  as512_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state_q == REQ),
    .tc   (tmo_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and transfer-event decode
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    viol     = 1'b0;
    case (state_q)
      IDLE: begin
        if (opreq) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        viol = opreq;
        if (mem_ready) begin
          done_ok = 1'b1;
          state_d = DONE;
        end else if (tmo_tc) begin
          done_tmo = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        viol    = opreq;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address latch; the opreq update comes first so a same-cycle latch takes precedence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      addr_fresh_q <= 1'b1;
    end else begin
      if (accept) begin
        addr_q       <= op_addr;
        addr_fresh_q <= 1'b0;
      end
      if (len1) begin
        addr_q[15:0] <= bus_dout;
        addr_fresh_q <= 1'b1;
      end else if (len2) begin
        addr_q[ADDR_W-1:16] <= bus_dout[ADDR_W-17:0];
        addr_fresh_q        <= 1'b1;
      end
    end
  end

  // Memory-side request and read-data return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_req   <= 1'b0;
      bus_din   <= '0;
    end else if (accept) begin
      mem_addr <= op_addr;
      mem_we   <= rw;
      mem_req  <= 1'b1;
      if (rw) mem_wdata <= bus_dout;
    end else if (done_ok || done_tmo) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      if (!mem_we) bus_din <= done_ok ? mem_rdata : READ_ABORT_VAL;
    end
  end

  // Sticky error; a new error outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            err <= 1'b0;
    else if (both_len || viol || done_tmo) err <= 1'b1;
    else if (err_clr)                    err <= 1'b0;
  end

endmodule

// File: tb/tb_as512_bus_bridge.sv
// tb/tb_as512_bus_bridge.sv - self-checking bench for as512_bus_bridge
module tb_as512_bus_bridge;

  localparam int AW  = 24;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   bus_dout, bus_din, mem_wdata, mem_rdata;
  logic          len1, len2, rw, opreq, wait_o, mem_we, mem_req, mem_ready, err, err_clr;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] m_addr;
  bit            m_fresh;
  bit            m_err;
  logic [15:0]   m_din;

  as512_bus_bridge #(.ADDR_W(AW), .AUTOINC(1), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_dout  (bus_dout),
    .bus_din   (bus_din),
    .len1      (len1),
    .len2      (len2),
    .rw        (rw),
    .opreq     (opreq),
    .wait_o    (wait_o),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_req   (mem_req),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_addr  = '0;
    m_fresh = 1'b1;
    m_err   = 1'b0;
    m_din   = 16'h0000;
  endtask

  task automatic latch(input bit l1, input bit l2, input logic [15:0] d);
    @(negedge clk);
    len1 = l1; len2 = l2; bus_dout = d;
    if (l1)      m_addr[15:0]  = d;
    else if (l2) m_addr[23:16] = d[7:0];
    if (l1 || l2) m_fresh = 1'b1;
    if (l1 && l2) m_err = 1'b1;
    @(negedge clk);
    len1 = 1'b0; len2 = 1'b0;
    #1 check_val("err_after_latch", 32'(err), 32'(m_err));
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 1'b0;
    #1 check_val("err_cleared", 32'(err), 32'(m_err));
  endtask

  // k: REQ cycle (1-based) in which mem_ready is raised; 0 means never
  task automatic do_op(input bit w, input logic [15:0] d, input int k, input bit inject);
    logic [AW-1:0] exp_a;
    logic [15:0]   rd;
    int            waits, exp_waits;
    bit            got_ready, done;
    exp_a   = m_fresh ? m_addr : m_addr + 24'd1;
    m_addr  = exp_a;
    m_fresh = 1'b0;
    @(negedge clk);
    opreq = 1'b1; rw = w; bus_dout = d;
    #1 check_val("wait_strobe", 32'(wait_o), 32'd1);
    waits = 1; got_ready = 1'b0; done = 1'b0;
    for (int c = 1; c <= TMO + 3; c++) begin
      @(negedge clk);
      opreq     = inject && (c == 1);
      rw        = 1'b1;
      mem_ready = (c == k);
      rd        = 16'($urandom);
      mem_rdata = rd;
      #1;
      if (!wait_o) begin
        done = 1'b1;
        break;
      end
      waits++;
      if (c <= 2) begin
        check_val("mem_req", 32'(mem_req), 32'd1);
        check_val("mem_addr", 32'(mem_addr), 32'(exp_a));
        check_val("mem_we", 32'(mem_we), 32'(w));
        if (w) check_val("mem_wdata", 32'(mem_wdata), 32'(d));
      end
      if (mem_ready) begin
        got_ready = 1'b1;
        if (!w) m_din = rd;
      end
    end
    mem_ready = 1'b0;
    opreq     = 1'b0;
    if (!got_ready) begin
      m_err = 1'b1;
      if (!w) m_din = 16'hFFFF;
    end
    if (inject) m_err = 1'b1;
    exp_waits = 1 + ((k >= 1 && k <= TMO) ? k : TMO);
    check_val("op_finished", 32'(done), 32'd1);
    check_val("wait_cycles", 32'(waits), 32'(exp_waits));
    check_val("bus_din", 32'(bus_din), 32'(m_din));
    check_val("err", 32'(err), 32'(m_err));
    check_val("mem_req_done", 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; bus_dout = '0; len1 = 0; len2 = 0; rw = 0; opreq = 0;
    mem_ready = 0; mem_rdata = '0; err_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_bus_din", 32'(bus_din), 32'd0);
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_wait", 32'(wait_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // first strobe after reset with no latch targets address 0
    do_op(0, 16'h0000, 1, 0);

    // latch + zero-wait write
    latch(1, 0, 16'h1234);
    latch(0, 1, 16'h0056);
    do_op(1, 16'hBEEF, 1, 0);

    // read with waits
    latch(1, 0, 16'h0010);
    latch(0, 1, 16'h0000);
    do_op(0, 16'h0000, 3, 0);

    // auto-increment wrap
    latch(1, 0, 16'hFFFF);
    latch(0, 1, 16'h00FF);
    do_op(0, 16'h0000, 1, 0);
    do_op(0, 16'h0000, 1, 0);

    // timeout on a read, ready on the terminal cycle, then clear
    do_op(0, 16'h0000, 0, 0);
    clear_err();
    do_op(0, 16'h0000, TMO, 0);
    check_val("ready_on_tc_no_err", 32'(err), 32'd0);

    // simultaneous latch enables, then opreq during REQ
    latch(1, 1, 16'hCAFE);
    do_op(1, 16'h5A5A, 2, 0);
    clear_err();
    do_op(0, 16'h0000, 3, 1);
    clear_err();

    // async reset mid-transfer
    @(negedge clk);
    opreq = 1'b1; rw = 1'b0;
    @(negedge clk);
    opreq = 1'b0;
    #1 check_val("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    check_val("async_mem_req", 32'(mem_req), 32'd0);
    check_val("async_wait", 32'(wait_o), 32'd0);
    check_val("async_err", 32'(err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    do_op(0, 16'h0000, 1, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        1: latch(1, 0, 16'($urandom));
        2: latch(0, 1, 16'($urandom));
        3: begin
          latch(1, 0, 16'($urandom));
          latch(0, 1, 16'($urandom));
        end
        4: latch(1, 1, 16'($urandom));
        default: ;
      endcase
      do_op(1'($urandom), 16'($urandom), int'($urandom_range(0, TMO + 1)),
            ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) clear_err();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
